if_id_pipe_stage: RTL and testbench
===================================

// Module: if_id_pipe_stage
// PURPOSE
//  Parametrised IF->ID pipeline register with valid/ready handshake, flush-to-bubble and hold.
//  Carries instruction, fetch PC and PC+PC_INC into decode; flush injects NOP_VAL.
//  Sits between fetch and decode; also reusable between any two core stages.
//  Counts flushes for hazard-unit debug.
// PARAMETERS
//  DATA_W   32   instruction/payload width
//  PC_W     32   PC width
//  PC_INC   4    increment added to in_pc on normal capture
//  NOP_VAL  0    payload loaded on flush and on reset (DATA_W bits)
//  CNT_W    8    flush counter width
// PORTS
//  clk            in   1       clock, all state on rising edge
//  rst_n          in   1       asynchronous active-low reset
//  flush          in   1       discard stage contents, insert bubble
//  hold           in   1       freeze all stage state (stall)
//  in_valid       in   1       fetch presents instruction
//  in_ready       out  1       stage can accept this cycle
//  in_instr       in   DATA_W  fetched instruction
//  in_pc          in   PC_W    PC of fetched instruction
//  out_valid      out  1       decode-side entry valid
//  out_ready      in   1       decode consumes entry this cycle
//  out_instr      out  DATA_W  instruction to decode
//  out_pc         out  PC_W    PC of out_instr
//  out_pc_plus    out  PC_W    out_pc+PC_INC (flush: in_pc unmodified)
//  flush_cnt      out  CNT_W   saturating count of applied flushes
// BEHAVIOUR
//  Reset (rst_n=0, async): out_valid=0, out_instr=NOP_VAL, out_pc=0, out_pc_plus=0,
//   flush_cnt=0, skid empty. Reset mid-transfer drops all entries; no partial state.
//  Accept = in_valid & in_ready; consume = out_valid & out_ready. Latency 1 cycle in->out.
//  Priority per edge: hold > flush > data movement.
//  hold=1: every register keeps its value; in_ready=0; flush ignored, not counted.
//  flush=1 & hold=0: out_valid<=0, out_instr<=NOP_VAL, out_pc<=in_pc, out_pc_plus<=in_pc
//   (no increment), skid cleared, flush_cnt+=1 saturating at 2^CNT_W-1; input not accepted
//   that cycle.
//  Normal: on accept into output reg: out_instr<=in_instr, out_pc<=in_pc,
//   out_pc_plus<=in_pc+PC_INC (mod 2^PC_W, wraps silently), out_valid<=1.
//  If consume without accept: out_valid<=0, payload regs unchanged.
//  out_* stable while out_valid=1 & out_ready=0 (no change without consume/flush/reset).
//  in_valid must not depend on in_ready; in_ready may depend on out_ready (non-skid only).
// CONFIGURATION
//  IF_ID_SKID_EN defined: 2-entry stage (output reg + skid reg). in_ready is registered:
//   in_ready = ~skid_valid & ~hold. Accept while output full and ~consume -> data to skid.
//   On consume with skid_valid: skid moves to output reg same edge; simultaneous accept
//   refills skid. Full throughput, no combinational out_ready->in_ready path.
//  IF_ID_SKID_EN undefined: single entry; in_ready = ~hold & ~flush & (~out_valid | out_ready)
//   (combinational); skid logic absent.
// TESTING
//  1 Reset: rst_n low mid-cycle, hold=0 -> immediately out_valid=0, out_instr=NOP_VAL, flush_cnt=0.
//  2 Stream: in_instr=0x00500093, in_pc=0x100, out_ready=1 -> next cycle out_valid=1,
//    out_pc=0x100, out_pc_plus=0x104; 4 back-to-back, one per cycle, in order.
//  3 Flush: full stage, in_pc=0x200, flush=1 -> out_valid=0, out_instr=NOP_VAL,
//    out_pc_plus=0x200, flush_cnt=1; with CNT_W=2 five flushes -> flush_cnt=3.
//  4 Hold vs flush: hold=1 & flush=1 with out_instr=0xA -> all outputs unchanged, flush_cnt
//    unchanged, in_ready=0.
//  5 Backpressure: out_ready=0 for 3 cycles -> out_* stable; skid build accepts exactly one
//    extra then in_ready=0; release -> both delivered in order, no loss/duplicate.
//  6 Wrap: in_pc=0xFFFFFFFC -> out_pc_plus=0x00000000.

Source files
------------

// File: rtl/if_id_pipe_stage_if.sv
// Handshake/payload bundle between fetch, the IF->ID register and decode.
// slave: the pipeline register itself; master: the fetch/decode environment around it.
interface if_id_pipe_stage_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PC_W   = 32
) ();
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_instr;
    logic [PC_W-1:0]   in_pc;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_instr;
    logic [PC_W-1:0]   out_pc;
    logic [PC_W-1:0]   out_pc_plus;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, out_pc_plus
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc, out_pc_plus
    );
endinterface

// File: rtl/if_id_pipe_stage.sv
// IF->ID pipeline register with valid/ready handshake, flush-to-bubble, hold and a flush counter.
// Define IF_ID_SKID_EN for a 2-entry stage (output + skid register) with a registered in_ready.
module if_id_pipe_stage #(
    parameter int unsigned       DATA_W  = 32,
    parameter int unsigned       PC_W    = 32,
    parameter int unsigned       PC_INC  = 4,
    parameter logic [DATA_W-1:0] NOP_VAL = '0,
    parameter int unsigned       CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               hold,
    if_id_pipe_stage_if.slave  bus,
    output logic [CNT_W-1:0]   flush_cnt
);

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [PC_W-1:0]   pc;
        logic [PC_W-1:0]   pc_plus;
    } entry_t;

    localparam entry_t RST_ENTRY = '{instr: NOP_VAL, pc: '0, pc_plus: '0};

    entry_t            out_q, out_d;
    logic              out_valid_q, out_valid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    entry_t            in_entry;
    entry_t            flush_entry;
    logic              accept;
    logic              consume;

    // A flush bubble carries the incoming PC unincremented so redirect logic can see it.
    assign in_entry    = '{instr: bus.in_instr, pc: bus.in_pc, pc_plus: bus.in_pc + PC_W'(PC_INC)};
    assign flush_entry = '{instr: NOP_VAL, pc: bus.in_pc, pc_plus: bus.in_pc};

`ifdef IF_ID_SKID_EN
    entry_t skid_q, skid_d;
    logic   skid_valid_q, skid_valid_d;

    assign bus.in_ready = ~skid_valid_q & ~hold;
`else
    assign bus.in_ready = ~hold & ~flush & (~out_valid_q | bus.out_ready);
`endif

    assign accept  = bus.in_valid & bus.in_ready;
    assign consume = out_valid_q & bus.out_ready;

    // Next-state: hold freezes everything, flush beats data movement.
    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        cnt_d       = cnt_q;
`ifdef IF_ID_SKID_EN
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
`endif
        if (!hold) begin
            if (flush) begin
                out_valid_d = 1'b0;
                out_d       = flush_entry;
                cnt_d       = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
`ifdef IF_ID_SKID_EN
                skid_valid_d = 1'b0;
`endif
            end else begin
`ifdef IF_ID_SKID_EN
                if (!out_valid_q || consume) begin
                    if (skid_valid_q) begin
                        out_d        = skid_q;
                        out_valid_d  = 1'b1;
                        skid_valid_d = accept;
                        if (accept) begin
                            skid_d = in_entry;
                        end
                    end else if (accept) begin
                        out_d       = in_entry;
                        out_valid_d = 1'b1;
                    end else begin
                        out_valid_d = 1'b0;
                    end
                end else if (accept) begin
                    skid_d       = in_entry;
                    skid_valid_d = 1'b1;
                end
`else
                if (accept) begin
                    out_d       = in_entry;
                    out_valid_d = 1'b1;
                end else if (consume) begin
                    out_valid_d = 1'b0;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= RST_ENTRY;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end

`ifdef IF_ID_SKID_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_q       <= RST_ENTRY;
            skid_valid_q <= 1'b0;
        end else begin
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end
`endif

    assign bus.out_valid   = out_valid_q;
    assign bus.out_instr   = out_q.instr;
    assign bus.out_pc      = out_q.pc;
    assign bus.out_pc_plus = out_q.pc_plus;
    assign flush_cnt       = cnt_q;

endmodule

// File: tb/tb_if_id_pipe_stage.sv
// Directed bench for if_id_pipe_stage: reset, streaming, flush/saturation, hold, backpressure, PC wrap.
module tb_if_id_pipe_stage;

    localparam int unsigned       DATA_W  = 32;
    localparam int unsigned       PC_W    = 32;
    localparam int unsigned       CNT_W   = 2;
    localparam logic [DATA_W-1:0] NOP     = 32'h0000_0013;
`ifdef IF_ID_SKID_EN
    localparam logic SKID = 1'b1;
`else
    localparam logic SKID = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             hold;
    logic [CNT_W-1:0] flush_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    if_id_pipe_stage_if #(.DATA_W(DATA_W), .PC_W(PC_W)) bus ();

    if_id_pipe_stage #(
        .DATA_W (DATA_W),
        .PC_W   (PC_W),
        .PC_INC (4),
        .NOP_VAL(NOP),
        .CNT_W  (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .hold     (hold),
        .bus      (bus),
        .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] bp_instr [3];
    logic [31:0] bp_pc    [3];
    logic [31:0] st_instr [4];

    initial begin
        int  idx;
        int  got;
        int  extra;
        logic acc;
        logic cons;

        bp_instr = '{32'h0000_1000, 32'h0000_2000, 32'h0000_3000};
        bp_pc    = '{32'h0000_0500, 32'h0000_0504, 32'h0000_0508};
        st_instr = '{32'h0050_0093, 32'h00A0_0113, 32'h00F0_0193, 32'h0140_0213};

        rst_n         = 1'b0;
        flush         = 1'b0;
        hold          = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_pc     = '0;
        bus.out_ready = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
        #1;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_instr", bus.out_instr, NOP);
        chk("rst_pc", bus.out_pc, 0);
        chk("rst_pc_plus", bus.out_pc_plus, 0);
        chk("rst_cnt", flush_cnt, 0);
        chk("rst_ready", bus.in_ready, 1);

        // Streaming: one instruction per cycle, in order
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_instr = st_instr[i];
            bus.in_pc    = 32'h100 + 32'(4 * i);
            cyc();
            chk("stream_valid", bus.out_valid, 1);
            chk("stream_instr", bus.out_instr, st_instr[i]);
            chk("stream_pc", bus.out_pc, 32'h100 + 32'(4 * i));
            chk("stream_pc_plus", bus.out_pc_plus, 32'h104 + 32'(4 * i));
        end
        bus.in_valid = 1'b0;
        cyc();
        chk("drain_valid", bus.out_valid, 0);
        chk("drain_instr_kept", bus.out_instr, 32'h0140_0213);

        // Asynchronous reset mid-cycle with the stage full
        bus.in_valid = 1'b1;
        bus.in_instr = 32'hDEAD_BEEF;
        bus.in_pc    = 32'h300;
        cyc();
        chk("pre_rst_valid", bus.out_valid, 1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", bus.out_valid, 0);
        chk("async_rst_instr", bus.out_instr, NOP);
        chk("async_rst_pc_plus", bus.out_pc_plus, 0);
        chk("async_rst_cnt", flush_cnt, 0);
        cyc();
        rst_n = 1'b1;

        // Flush of a full stage
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h1111_1111;
        bus.in_pc    = 32'h1F0;
        cyc();
        chk("fill_valid", bus.out_valid, 1);
        flush        = 1'b1;
        bus.in_instr = 32'h2222_2222;
        bus.in_pc    = 32'h200;
        #1;
        chk("flush_ready", bus.in_ready, SKID);
        cyc();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_valid", bus.out_valid, 0);
        chk("flush_instr", bus.out_instr, NOP);
        chk("flush_pc", bus.out_pc, 32'h200);
        chk("flush_pc_plus", bus.out_pc_plus, 32'h200);
        chk("flush_cnt1", flush_cnt, 1);

        // Hold overrides flush and consume
        bus.in_valid = 1'b1;
        bus.in_instr = 32'hA;
        bus.in_pc    = 32'h40;
        cyc();
        hold          = 1'b1;
        flush         = 1'b1;
        bus.in_instr  = 32'hBB;
        bus.in_pc     = 32'h80;
        bus.out_ready = 1'b1;
        #1;
        chk("hold_ready", bus.in_ready, 0);
        cyc();
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_instr", bus.out_instr, 32'hA);
        chk("hold_pc", bus.out_pc, 32'h40);
        chk("hold_pc_plus", bus.out_pc_plus, 32'h44);
        chk("hold_cnt", flush_cnt, 1);
        hold         = 1'b0;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        cyc();
        chk("post_hold_consume", bus.out_valid, 0);

        // Flush counter saturation (5 flushes total with 2-bit counter)
        flush = 1'b1;
        cyc();
        chk("flush_cnt2", flush_cnt, 2);
        repeat (3) cyc();
        flush = 1'b0;
        chk("flush_cnt_sat", flush_cnt, 3);

        // Backpressure: three stalled cycles, then release
        idx   = 0;
        got   = 0;
        extra = 0;
        for (int c = 0; c < 10; c++) begin
            bus.out_ready = (c >= 4);
            bus.in_valid  = (idx < 3);
            bus.in_instr  = (idx < 3) ? bp_instr[idx] : 32'h0;
            bus.in_pc     = (idx < 3) ? bp_pc[idx] : 32'h0;
            #1;
            acc  = bus.in_valid & bus.in_ready;
            cons = bus.out_valid & bus.out_ready;
            if (c >= 1 && c <= 3) begin
                if (acc) extra++;
                chk("bp_stall_valid", bus.out_valid, 1);
                chk("bp_stall_instr", bus.out_instr, bp_instr[0]);
                chk("bp_stall_pc_plus", bus.out_pc_plus, 32'h504);
            end
            if (cons) begin
                if (got < 3) begin
                    chk("bp_order_instr", bus.out_instr, bp_instr[got]);
                    chk("bp_order_pc", bus.out_pc, bp_pc[got]);
                end
                got++;
            end
            cyc();
            if (acc) idx++;
        end
        chk("bp_extra_accepts", 64'(extra), 64'(SKID));
        chk("bp_all_accepted", 64'(idx), 3);
        chk("bp_delivered", 64'(got), 3);
        chk("bp_empty_after", bus.out_valid, 0);

        // PC+4 wraps at the top of the address space
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'h0000_0073;
        bus.in_pc     = 32'hFFFF_FFFC;
        cyc();
        bus.in_valid = 1'b0;
        chk("wrap_pc", bus.out_pc, 32'hFFFF_FFFC);
        chk("wrap_pc_plus", bus.out_pc_plus, 32'h0000_0000);
        chk("wrap_valid", bus.out_valid, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
